aes256_input_packer: RTL
========================

AES256_INPUT_PACKER -- requirements
Module: aes256_input_packer

Interface
REQ-001 The block SHALL have parameter MODE_ENC, default 2'b00, meaning the mod_en code for encryption blocks.
REQ-002 The block SHALL have parameter MODE_DEC, default 2'b01, meaning the mod_en code for decryption blocks.
REQ-003 The block SHALL have parameter MODE_KEY, default 2'b10, meaning the mod_en code for the 256-bit key load.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk  in  1  is the single clock; all logic is on the rising edge.
REQ-006 Port reset  in  1  is the synchronous, active-high reset.
REQ-007 Port s_tdata  in  32  is the upstream data word.
REQ-008 Port s_tuser  in  2  is the mode tag of the current word.
REQ-009 Port s_tlast  in  1  marks the final word of a block.
REQ-010 Port s_tvalid  in  1  indicates the upstream word is valid.
REQ-011 Port s_tready  out  1  indicates the block accepts a word.
REQ-012 Port dev_ready  in  1  indicates the AES256 device can take a block.
REQ-013 Port inp_device  out  128  is the block presented to the device.
REQ-014 Port mod_en  out  2  is the mode presented with inp_device.
REQ-015 Port ctrl_dataIn  out  1  is a one-cycle strobe marking inp_device/mod_en valid.
REQ-016 Port err_len  out  1  is a one-cycle pulse on an early s_tlast.
REQ-017 Port err_mode  out  1  is a one-cycle pulse on an illegal or changed mode.
REQ-018 Port blk_count  out  16  counts issued ENC/DEC blocks.

Function
REQ-019 A word SHALL transfer on a rising edge where s_tvalid and s_tready are both 1.
REQ-020 The FSM SHALL have states FILL, WAIT_DEV, ISSUE_LO and ISSUE_HI.
REQ-021 In FILL, s_tready SHALL be 1; in all other states it SHALL be 0.
REQ-022 The first word of a block SHALL latch s_tuser as the block mode, and word k SHALL be stored at buffer bits [32k+31:32k].
REQ-023 A block SHALL be complete after 4 words for MODE_ENC/MODE_DEC and after 8 words for MODE_KEY; on completion the FSM SHALL go FILL->WAIT_DEV.
REQ-024 s_tlast on the final word SHALL be accepted, and s_tlast absent on the final word SHALL still complete the block.
REQ-025 s_tlast on a non-final word SHALL pulse err_len for one cycle, discard the partial block including that word, and remain in FILL with the count at 0.
REQ-026 A word whose s_tuser is not one of the three mode codes, or whose s_tuser differs from the latched mode mid-block, SHALL pulse err_mode for one cycle, discard the partial block including that word, and reset the count to 0.
REQ-027 If err_len and err_mode conditions occur on the same word, both pulses SHALL assert.
REQ-028 In WAIT_DEV with dev_ready=1 at an edge, the FSM SHALL go to ISSUE_LO; otherwise it SHALL hold, retaining the buffer.
REQ-029 In ISSUE_LO, ctrl_dataIn SHALL be 1, inp_device SHALL equal buffer[127:0], and mod_en SHALL equal the latched mode, for exactly one cycle.
REQ-030 After ISSUE_LO, a key block SHALL go to ISSUE_HI unconditionally; an ENC/DEC block SHALL go to FILL.
REQ-031 In ISSUE_HI, ctrl_dataIn SHALL be 1, inp_device SHALL equal buffer[255:128], and mod_en SHALL equal MODE_KEY, for exactly one cycle, then the FSM SHALL go to FILL.
REQ-032 The key halves SHALL be issued on back-to-back cycles regardless of dev_ready.
REQ-033 All outputs SHALL be registered.
REQ-034 Latency: with dev_ready=1, ctrl_dataIn SHALL rise 2 edges after the edge accepting the final word.
REQ-035 Outside the issue states, ctrl_dataIn SHALL be 0 and inp_device/mod_en SHALL hold their last values.
REQ-036 blk_count SHALL increment by 1 in each ISSUE_LO cycle of an ENC/DEC block, wrap from 16'hFFFF to 0, and not count key loads.

Reset
REQ-037 While reset=1 at an edge, the state SHALL go to FILL, the word count to 0, and the latched mode to MODE_ENC.
REQ-038 Reset SHALL clear inp_device, mod_en, ctrl_dataIn, err_len, err_mode and blk_count to 0; s_tready SHALL be 1 after reset.
REQ-039 Reset asserted in any state, including mid-block or between key halves, SHALL discard all buffered data with no further ctrl_dataIn pulse.

Verification
REQ-040 Key load: 8 words 32'h03020100..32'h1f1e1d1c with MODE_KEY and dev_ready=1 -> two consecutive ctrl_dataIn cycles with inp_device 128'h0f0e0d0c0b0a09080706050403020100 then 128'h1f1e1d1c1b1a19181716151413121110, mod_en=2'b10 both, and blk_count unchanged.
REQ-041 Encrypt: 4 words 32'h00112233..32'hccddeeff with MODE_ENC -> one ctrl_dataIn with inp_device 128'hccddeeff8899aabb4455667700112233, mod_en=00, blk_count=1, strobe 2 edges after the last word.
REQ-042 Backpressure: dev_ready=0 for 10 cycles after a complete DEC block -> s_tready=0 and no strobe throughout; dev_ready=1 -> one strobe, mod_en=01.
REQ-043 Errors: s_tlast on word 2 of an ENC block -> err_len pulse, nothing issued; mode change on word 3 -> err_mode pulse; s_tuser=2'b11 -> err_mode pulse; a following clean block issues normally.
REQ-044 Reset in ISSUE_LO of a key block -> no ISSUE_HI strobe, all outputs 0; blk_count preset to 16'hFFFF plus one ENC block -> blk_count 0.

Source files
------------

// File: rtl/aes256_input_packer.sv
// aes256_input_packer
// Packs a 32-bit word stream into 128-bit blocks for an AES256 core.
// ENC/DEC blocks are 4 words and are issued as one 128-bit transfer.
// Key loads are 8 words and are issued as two back-to-back 128-bit transfers,
// low half first.
//
// Upstream handshake: a word moves on a rising edge where s_tvalid and
// s_tready are both 1. s_tready is 1 exactly while the FSM is in FILL.
// Downstream there is no backpressure once issuing starts. dev_ready only
// gates the move out of WAIT_DEV. ctrl_dataIn qualifies inp_device/mod_en
// for the single cycle it is high.
//
// All outputs come straight from flops. The issue-state outputs are loaded
// on the edge that leaves each issue state. As a result, ctrl_dataIn rises
// two edges after the edge that accepts a block's final word.
module aes256_input_packer #(
    parameter logic [1:0] MODE_ENC = 2'b00,
    parameter logic [1:0] MODE_DEC = 2'b01,
    parameter logic [1:0] MODE_KEY = 2'b10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  s_tdata,
    input  logic [1:0]   s_tuser,
    input  logic         s_tlast,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         dev_ready,
    output logic [127:0] inp_device,
    output logic [1:0]   mod_en,
    output logic         ctrl_dataIn,
    output logic         err_len,
    output logic         err_mode,
    output logic [15:0]  blk_count
);

    // FSM encoding
    localparam logic [1:0] ST_FILL     = 2'd0;
    localparam logic [1:0] ST_WAIT_DEV = 2'd1;
    localparam logic [1:0] ST_ISSUE_LO = 2'd2;
    localparam logic [1:0] ST_ISSUE_HI = 2'd3;

    // Control state
    logic [1:0]   state_q,     state_d;
    logic [2:0]   cnt_q,       cnt_d;
    logic [1:0]   mode_q,      mode_d;

    // Block buffer (data only, no reset needed)
    logic [255:0] buf_q,       buf_d;

    // Registered outputs
    logic         tready_q,    tready_d;
    logic [127:0] inp_q,       inp_d;
    logic [1:0]   mod_q,       mod_d;
    logic         strobe_q,    strobe_d;
    logic         err_len_q,   err_len_d;
    logic         err_mode_q,  err_mode_d;
    logic [15:0]  blk_count_q, blk_count_d;

    // Word-level decode
    logic word_acc;
    logic first_word;
    logic mode_legal;
    logic mode_changed;
    logic bad_mode;
    logic blk_is_key;
    logic final_word;
    logic early_last;

    // A word is taken only in FILL, which is exactly when s_tready is high.
    assign word_acc     = s_tvalid && (state_q == ST_FILL);
    assign first_word   = (cnt_q == 3'd0);
    assign mode_legal   = (s_tuser == MODE_ENC) || (s_tuser == MODE_DEC) ||
                          (s_tuser == MODE_KEY);
    assign mode_changed = !first_word && (s_tuser != mode_q);
    assign bad_mode     = !mode_legal || mode_changed;

    // The block length comes from the incoming tag on the first word and
    // from the latched mode afterwards. An illegal tag counts as a 4-word
    // block. That only matters for deciding whether its tlast is early.
    assign blk_is_key   = first_word ? (s_tuser == MODE_KEY) : (mode_q == MODE_KEY);
    assign final_word   = blk_is_key ? (cnt_q == 3'd7) : (cnt_q == 3'd3);
    assign early_last   = s_tlast && !final_word;

    // Next-state and next-output logic for the whole block
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        buf_d       = buf_q;
        inp_d       = inp_q;
        mod_d       = mod_q;
        strobe_d    = 1'b0;
        err_len_d   = 1'b0;
        err_mode_d  = 1'b0;
        blk_count_d = blk_count_q;

        case (state_q)
            ST_FILL: begin
                if (word_acc) begin
                    if (bad_mode || early_last) begin
                        // Drop the partial block, including this word.
                        // Both error pulses may fire on the same word.
                        cnt_d      = 3'd0;
                        err_mode_d = bad_mode;
                        err_len_d  = early_last;
                    end else begin
                        buf_d[{cnt_q, 5'd0} +: 32] = s_tdata;
                        if (first_word) begin
                            mode_d = s_tuser;
                        end
                        if (final_word) begin
                            cnt_d   = 3'd0;
                            state_d = ST_WAIT_DEV;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end

            ST_WAIT_DEV: begin
                if (dev_ready) begin
                    state_d = ST_ISSUE_LO;
                end
            end

            ST_ISSUE_LO: begin
                strobe_d = 1'b1;
                inp_d    = buf_q[127:0];
                mod_d    = mode_q;
                if (mode_q == MODE_KEY) begin
                    // The key high half follows immediately. It does not
                    // wait for dev_ready again.
                    state_d = ST_ISSUE_HI;
                end else begin
                    state_d     = ST_FILL;
                    blk_count_d = blk_count_q + 16'd1;
                end
            end

            ST_ISSUE_HI: begin
                strobe_d = 1'b1;
                inp_d    = buf_q[255:128];
                mod_d    = MODE_KEY;
                state_d  = ST_FILL;
            end

            default: begin
                state_d = ST_FILL;
                cnt_d   = 3'd0;
            end
        endcase

        // s_tready is registered but always matches the state it sits beside.
        tready_d = (state_d == ST_FILL);
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FILL;
            cnt_q       <= 3'd0;
            mode_q      <= MODE_ENC;
            tready_q    <= 1'b1;
            inp_q       <= '0;
            mod_q       <= 2'b00;
            strobe_q    <= 1'b0;
            err_len_q   <= 1'b0;
            err_mode_q  <= 1'b0;
            blk_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            tready_q    <= tready_d;
            inp_q       <= inp_d;
            mod_q       <= mod_d;
            strobe_q    <= strobe_d;
            err_len_q   <= err_len_d;
            err_mode_q  <= err_mode_d;
            blk_count_q <= blk_count_d;
        end
    end

    // Block buffer. A reset drops its contents logically by restarting the
    // word count, so the storage itself is not cleared.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign s_tready    = tready_q;
    assign inp_device  = inp_q;
    assign mod_en      = mod_q;
    assign ctrl_dataIn = strobe_q;
    assign err_len     = err_len_q;
    assign err_mode    = err_mode_q;
    assign blk_count   = blk_count_q;

endmodule
